// File: rtl/fetch_unit.sv
// Instruction fetch front-end: sequential PC generation, one-outstanding imem
// request, and a small PC/word FIFO toward the decoder with redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]    state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next, kill_addr;
  logic [31:0]   target;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_word [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop;

  assign target     = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req   = (state == S_REQ) || (state == S_KILL);
  assign imem_addr  = (state == S_KILL) ? kill_addr : fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = fifo_word[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // A redirect flushes the FIFO, so it overrides both push and pop.
  assign pop        = inst_valid && inst_ready && !redirect;
  assign push       = (state == S_REQ) && imem_ack && !redirect;
  assign count_next = redirect ? '0 : count + CW'(push) - CW'(pop);

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    case (state)
      S_IDLE: begin
        if (redirect) fetch_pc_next = target;
        if (count_next < FULL) state_next = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            fetch_pc_next = target;
          end else begin
            fetch_pc_next = fetch_pc + 32'd4;
            if (!(count_next < FULL)) state_next = S_IDLE;
          end
        end else if (redirect) begin
          fetch_pc_next = target;
          state_next    = S_KILL;
        end
      end
      S_KILL: begin
        if (redirect) fetch_pc_next = target;
        if (imem_ack) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      kill_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
      end
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      // The stale request keeps driving its own address until it is acked.
      if ((state == S_REQ) && !imem_ack && redirect) kill_addr <= fetch_pc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]   <= fetch_pc;
          fifo_word[wr_ptr] <= imem_rdata;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory acks after lat wait cycles of an outstanding request.
  always @(negedge clock) begin
    if (imem_req) begin
      if (wait_cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = word_of(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    step(); step();
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_addr",  imem_addr,       32'h100);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",  inst,            32'd0);
    check("rst_pc",    inst_pc,         32'd0);

    // Sequential fetch with zero-wait memory
    reset = 1'b1; inst_ready = 1'b1;
    check("t1_first_idle", 32'(imem_req), 32'd0);
    step();
    check("t1_req",   32'(imem_req),   32'd1);
    check("t1_addr0", imem_addr,       32'h100);
    check("t1_valid0", 32'(inst_valid), 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check("t1_addr",  imem_addr,       32'h104 + 32'(4 * i));
      check("t1_valid", 32'(inst_valid), 32'd1);
      check("t1_pc",    inst_pc,         32'h100 + 32'(4 * i));
      check("t1_inst",  inst,            word_of(32'h100 + 32'(4 * i)));
    end

    // Back-pressure fills the FIFO and stops fetching
    redirect = 1'b1; redirect_pc = 32'h0; inst_ready = 1'b0;
    step();
    redirect = 1'b0;
    check("t2_req",    32'(imem_req),   32'd1);
    check("t2_addr0",  imem_addr,       32'h0);
    check("t2_valid0", 32'(inst_valid), 32'd0);
    step();
    check("t2_addr4",  imem_addr,       32'h4);
    check("t2_pc0",    inst_pc,         32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check("t2_full_req",   32'(imem_req),   32'd0);
      check("t2_full_valid", 32'(inst_valid), 32'd1);
      check("t2_full_pc",    inst_pc,         32'h0);
      check("t2_full_addr",  imem_addr,       32'h8);
    end
    inst_ready = 1'b1;
    step();
    check("t2_resume_req",  32'(imem_req), 32'd1);
    check("t2_resume_addr", imem_addr,     32'h8);
    check("t2_resume_pc",   inst_pc,       32'h4);
    step();
    check("t2_pc8",   inst_pc,   32'h8);
    check("t2_addrc", imem_addr, 32'hC);

    // Redirect coinciding with req&&ack: stale word dropped, FIFO flushed
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("t4_valid", 32'(inst_valid), 32'd0);
    check("t4_req",   32'(imem_req),   32'd1);
    check("t4_addr",  imem_addr,       32'h40);
    step();
    check("t4_valid1", 32'(inst_valid), 32'd1);
    check("t4_pc",     inst_pc,         32'h40);
    check("t4_inst",   inst,            word_of(32'h40));
    check("t4_addr44", imem_addr,       32'h44);

    // PC wrap and misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("t5_addr_top", imem_addr,       32'hFFFF_FFFC);
    check("t5_valid0",   32'(inst_valid), 32'd0);
    step();
    check("t5_pc_top",  inst_pc,       32'hFFFF_FFFC);
    check("t5_inst",    inst,          32'h2152_FFFC);
    check("t5_wrap",    imem_addr,     32'h0);
    check("t5_req",     32'(imem_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    check("t5_align_addr", imem_addr,       32'h200);
    check("t5_valid_fl",   32'(inst_valid), 32'd0);
    step();
    check("t5_pc200",  inst_pc,   32'h200);
    check("t5_addr204", imem_addr, 32'h204);

    // Slow memory, redirect in the first wait cycle -> KILL
    lat = 3; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      check("t3_kill_req",   32'(imem_req),   32'd1);
      check("t3_kill_addr",  imem_addr,       32'h204);
      check("t3_kill_valid", 32'(inst_valid), 32'd0);
      if (i < 2) step();
    end
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check("t3_new_addr",  imem_addr,       32'h200);
      check("t3_new_req",   32'(imem_req),   32'd1);
      check("t3_new_valid", 32'(inst_valid), 32'd0);
    end
    step();
    check("t3_pc",    inst_pc,         32'h200);
    check("t3_inst",  inst,            word_of(32'h200));
    check("t3_valid", 32'(inst_valid), 32'd1);
    check("t3_addr",  imem_addr,       32'h204);

    // Reset while KILL has its ack arriving
    redirect = 1'b1; redirect_pc = 32'h500;
    step();
    redirect = 1'b0;
    check("t6_kill_addr1", imem_addr, 32'h204);
    step();
    check("t6_kill_addr2", imem_addr, 32'h204);
    step();
    check("t6_kill_req3", 32'(imem_req), 32'd1);
    reset = 1'b0;
    step();
    check("t6_req",   32'(imem_req),   32'd0);
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_addr",  imem_addr,       32'h100);
    check("t6_inst",  inst,            32'd0);
    check("t6_pc",    inst_pc,         32'd0);
    reset = 1'b1; lat = 0;
    step();
    check("t6_restart_req",  32'(imem_req), 32'd1);
    check("t6_restart_addr", imem_addr,     32'h100);
    step();
    check("t6_restart_pc",   inst_pc,       32'h100);
    check("t6_restart_inst", inst,          word_of(32'h100));
    check("t6_restart_next", imem_addr,     32'h104);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
